awgn_sample_scheduler: RTL

- Control block in front of the AWGN datapath (dual Tausworthe URNG, log/sqrt/sin-cos, output multiply).
- Owns the six 32-bit URNG seed registers and loads them over a small config write port.
- Issues one datapath evaluation per granted request, advances the seed state, and shares the resulting (x0, x1) sample pair between two requesters using round-robin arbitration and a valid/ready handshake.

---
 rtl/awgn_sample_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/awgn_sample_scheduler.sv
// Control block in front of the AWGN datapath: owns the URNG seeds, issues one datapath
// evaluation per granted request and hands the resulting sample pair to one of two requesters.
module awgn_sample_scheduler #(
    parameter int DP_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic             cfg_err,
    output logic [191:0]     seed_bus,
    input  logic [191:0]     seed_next,
    output logic             dp_start,
    input  logic [15:0]      dp_x0,
    input  logic [15:0]      dp_x1,
    input  logic [1:0]       req,
    input  logic [1:0]       rdy,
    output logic [1:0]       vld,
    output logic [15:0]      smp_x0,
    output logic [15:0]      smp_x1,
    output logic             gnt_id,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t     state;
    logic       enable;
    logic       last_gnt;
    logic [3:0] lat_cnt;
    logic       wr_seed;
    logic       wr_ctrl;
    logic       wr_clr;
    logic       rr_pick;

    // Tausworthe components degenerate unless each seed exceeds its minimum.
    function automatic logic seeds_valid(input logic [191:0] s);
        return (s[31:0]    > 32'd1) && (s[63:32]   > 32'd7) && (s[95:64]   > 32'd15) &&
               (s[127:96]  > 32'd1) && (s[159:128] > 32'd7) && (s[191:160] > 32'd15);
    endfunction

    assign wr_seed = cfg_we && (cfg_addr <= 3'd5);
    assign wr_ctrl = cfg_we && (cfg_addr == 3'd6);
    assign wr_clr  = cfg_we && (cfg_addr == 3'd7);
    // A lone request wins outright; on a tie the requester not served last time wins.
    assign rr_pick = (req == 2'b11) ? ~last_gnt : req[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            enable     <= 1'b0;
            last_gnt   <= 1'b1;
            lat_cnt    <= '0;
            seed_bus   <= '0;
            cfg_err    <= 1'b0;
            dp_start   <= 1'b0;
            vld        <= 2'b00;
            smp_x0     <= '0;
            smp_x1     <= '0;
            gnt_id     <= 1'b0;
            busy       <= 1'b0;
            sample_cnt <= '0;
        end else begin
            cfg_err  <= 1'b0;
            dp_start <= 1'b0;
            if (wr_seed && state != S_IDLE) cfg_err <= 1'b1;
            if (wr_ctrl && !cfg_wdata[0]) enable <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (wr_seed) begin
                        for (int i = 0; i < 6; i++) begin
                            if (cfg_addr == 3'(i)) seed_bus[32*i +: 32] <= cfg_wdata;
                        end
                    end
                    if (wr_ctrl && cfg_wdata[0]) begin
                        if (seeds_valid(seed_bus)) begin
                            enable <= 1'b1;
                            state  <= S_READY;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (req != 2'b00) begin
                        gnt_id   <= rr_pick;
                        dp_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    seed_bus <= seed_next;
                    lat_cnt  <= 4'(DP_LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        smp_x0 <= dp_x0;
                        smp_x1 <= dp_x1;
                        vld    <= gnt_id ? 2'b10 : 2'b01;
                        state  <= S_DELIVER;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_DELIVER: begin
                    if (rdy[gnt_id]) begin
                        vld        <= 2'b00;
                        last_gnt   <= gnt_id;
                        sample_cnt <= sample_cnt + 1'b1;
                        busy       <= 1'b0;
                        state      <= enable ? S_READY : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // NOTE: placed after the FSM so this later non-blocking write overrides an accept-edge increment.
            if (wr_clr) sample_cnt <= '0;
        end
    end

endmodule
